// File: rtl/glb_proc_req_sched_if.sv
// Processor-side and packet-chain signal bundle for the request scheduler.
// The slave modport belongs to the scheduler; master is the processor/chain side.
interface glb_proc_req_sched_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 64
);
    logic                  proc_wr_en;
    logic [DATA_W/8-1:0]   proc_wr_strb;
    logic [ADDR_W-1:0]     proc_wr_addr;
    logic [DATA_W-1:0]     proc_wr_data;
    logic                  proc_wr_ready;
    logic                  proc_rd_en;
    logic [ADDR_W-1:0]     proc_rd_addr;
    logic                  proc_rd_ready;
    logic [DATA_W-1:0]     proc_rd_data;
    logic                  proc_rd_data_valid;

    logic                  wr_pkt_en;
    logic [DATA_W/8-1:0]   wr_pkt_strb;
    logic [ADDR_W-1:0]     wr_pkt_addr;
    logic [DATA_W-1:0]     wr_pkt_data;
    logic                  rdrq_pkt_en;
    logic [ADDR_W-1:0]     rdrq_pkt_addr;
    logic                  rdrs_pkt_valid;
    logic [DATA_W-1:0]     rdrs_pkt_data;

    logic [3:0]            outst_cnt;
    logic                  rd_timeout_err;
    logic                  spurious_rs_err;

    modport slave (
        input  proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
        input  proc_rd_en, proc_rd_addr,
        input  rdrs_pkt_valid, rdrs_pkt_data,
        output proc_wr_ready, proc_rd_ready, proc_rd_data, proc_rd_data_valid,
        output wr_pkt_en, wr_pkt_strb, wr_pkt_addr, wr_pkt_data,
        output rdrq_pkt_en, rdrq_pkt_addr,
        output outst_cnt, rd_timeout_err, spurious_rs_err
    );

    modport master (
        output proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
        output proc_rd_en, proc_rd_addr,
        output rdrs_pkt_valid, rdrs_pkt_data,
        input  proc_wr_ready, proc_rd_ready, proc_rd_data, proc_rd_data_valid,
        input  wr_pkt_en, wr_pkt_strb, wr_pkt_addr, wr_pkt_data,
        input  rdrq_pkt_en, rdrq_pkt_addr,
        input  outst_cnt, rd_timeout_err, spurious_rs_err
    );
endinterface

// File: rtl/glb_proc_req_sched.sv
// Round-robin write/read issue into the packet chain, credit-limited reads, in-order read return.
// Latency: request granted at edge N is on *_pkt_* in cycle N+1; response in cycle N returns in cycle N+1.
// Backpressure: ready is the combinational grant; reads stall while outst_cnt == MAX_OUTST.
module glb_proc_req_sched #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 64,
    parameter int MAX_OUTST  = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    glb_proc_req_sched_if.slave  bus
);
    logic       last_rd;
    logic [7:0] to_cnt;
    logic       wr_elig, rd_elig, wr_gnt, rd_gnt;
    logic       busy, rs_hit, rs_spur, tmo, retire;

    always_comb begin
        wr_elig = bus.proc_wr_en;
        rd_elig = bus.proc_rd_en && (bus.outst_cnt < 4'(MAX_OUTST));
        // On a tie the type not granted last time wins.
        wr_gnt  = wr_elig && (!rd_elig || last_rd);
        rd_gnt  = rd_elig && (!wr_elig || !last_rd);
        busy    = bus.outst_cnt != 4'd0;
        rs_hit  = bus.rdrs_pkt_valid && busy;
        rs_spur = bus.rdrs_pkt_valid && !busy;
        // A response on the expiry cycle takes precedence over the timeout.
        tmo     = busy && !bus.rdrs_pkt_valid && (to_cnt == 8'(RD_TIMEOUT - 1));
        retire  = rs_hit || tmo;
    end

    assign bus.proc_wr_ready = wr_gnt;
    assign bus.proc_rd_ready = rd_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_rd           <= 1'b1;
            bus.wr_pkt_en     <= 1'b0;
            bus.wr_pkt_strb   <= {(DATA_W/8){1'b0}};
            bus.wr_pkt_addr   <= {ADDR_W{1'b0}};
            bus.wr_pkt_data   <= {DATA_W{1'b0}};
            bus.rdrq_pkt_en   <= 1'b0;
            bus.rdrq_pkt_addr <= {ADDR_W{1'b0}};
        end else begin
            if (wr_gnt || rd_gnt)
                last_rd <= rd_gnt;
            bus.wr_pkt_en     <= wr_gnt;
            bus.wr_pkt_strb   <= wr_gnt ? bus.proc_wr_strb : {(DATA_W/8){1'b0}};
            bus.wr_pkt_addr   <= wr_gnt ? bus.proc_wr_addr : {ADDR_W{1'b0}};
            bus.wr_pkt_data   <= wr_gnt ? bus.proc_wr_data : {DATA_W{1'b0}};
            bus.rdrq_pkt_en   <= rd_gnt;
            bus.rdrq_pkt_addr <= rd_gnt ? bus.proc_rd_addr : {ADDR_W{1'b0}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.outst_cnt          <= 4'd0;
            to_cnt                 <= 8'd0;
            bus.proc_rd_data       <= {DATA_W{1'b0}};
            bus.proc_rd_data_valid <= 1'b0;
            bus.rd_timeout_err     <= 1'b0;
            bus.spurious_rs_err    <= 1'b0;
        end else begin
            case ({rd_gnt, retire})
                2'b10:   bus.outst_cnt <= bus.outst_cnt + 4'd1;
                2'b01:   bus.outst_cnt <= bus.outst_cnt - 4'd1;
                default: bus.outst_cnt <= bus.outst_cnt;
            endcase
            // The timer measures silence on the oldest outstanding read only.
            if (!busy || bus.rdrs_pkt_valid || tmo)
                to_cnt <= 8'd0;
            else
                to_cnt <= to_cnt + 8'd1;
            bus.proc_rd_data_valid <= retire;
            if (retire)
                bus.proc_rd_data <= rs_hit ? bus.rdrs_pkt_data : {DATA_W{1'b0}};
            if (tmo)
                bus.rd_timeout_err <= 1'b1;
            if (rs_spur)
                bus.spurious_rs_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_glb_proc_req_sched.sv
// Directed stimulus for glb_proc_req_sched with a queue scoreboard and a negedge output monitor.
module tb_glb_proc_req_sched;
    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 64;
    localparam int MAX_OUTST  = 4;
    localparam int RD_TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    glb_proc_req_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    glb_proc_req_sched #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
    } wr_exp_t;

    wr_exp_t           wr_q[$];
    logic [ADDR_W-1:0] rq_q[$];
    logic [DATA_W-1:0] rs_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output seen with no expectation queued", name);
    endtask

    // Monitor: every packet or read return must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_exp_t           e;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        if (bus.wr_pkt_en === 1'b1) begin
            if (wr_q.size() == 0) unexpected("wr_pkt");
            else begin
                e = wr_q.pop_front();
                chk("wr_pkt_addr", bus.wr_pkt_addr, e.addr);
                chk("wr_pkt_data", bus.wr_pkt_data, e.data);
                chk("wr_pkt_strb", bus.wr_pkt_strb, e.strb);
            end
            chk("rdrq_idle_en", bus.rdrq_pkt_en, 0);
            chk("rdrq_idle_addr", bus.rdrq_pkt_addr, 0);
        end
        if (bus.rdrq_pkt_en === 1'b1) begin
            if (rq_q.size() == 0) unexpected("rdrq_pkt");
            else begin
                a = rq_q.pop_front();
                chk("rdrq_pkt_addr", bus.rdrq_pkt_addr, a);
            end
            chk("wr_idle_addr", bus.wr_pkt_addr, 0);
            chk("wr_idle_data", bus.wr_pkt_data, 0);
            chk("wr_idle_strb", bus.wr_pkt_strb, 0);
        end
        if (bus.proc_rd_data_valid === 1'b1) begin
            if (rs_q.size() == 0) unexpected("proc_rd_data_valid");
            else begin
                d = rs_q.pop_front();
                chk("proc_rd_data", bus.proc_rd_data, d);
            end
        end
    end

    task automatic idle_inputs();
        bus.proc_wr_en     = 1'b0;
        bus.proc_wr_strb   = '0;
        bus.proc_wr_addr   = '0;
        bus.proc_wr_data   = '0;
        bus.proc_rd_en     = 1'b0;
        bus.proc_rd_addr   = '0;
        bus.rdrs_pkt_valid = 1'b0;
        bus.rdrs_pkt_data  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/wr_pkt_en"},          bus.wr_pkt_en, 0);
        chk({tag, "/wr_pkt_addr"},        bus.wr_pkt_addr, 0);
        chk({tag, "/wr_pkt_data"},        bus.wr_pkt_data, 0);
        chk({tag, "/rdrq_pkt_en"},        bus.rdrq_pkt_en, 0);
        chk({tag, "/proc_rd_data_valid"}, bus.proc_rd_data_valid, 0);
        chk({tag, "/proc_rd_data"},       bus.proc_rd_data, 0);
        chk({tag, "/outst_cnt"},          bus.outst_cnt, 0);
        chk({tag, "/rd_timeout_err"},     bus.rd_timeout_err, 0);
        chk({tag, "/spurious_rs_err"},    bus.spurious_rs_err, 0);
        chk({tag, "/proc_wr_ready"},      bus.proc_wr_ready, 0);
        chk({tag, "/proc_rd_ready"},      bus.proc_rd_ready, 0);
    endtask

    // All tasks below start and end on a falling edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        idle_inputs();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issue_wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [DATA_W/8-1:0] strb);
        bus.proc_wr_en   = 1'b1;
        bus.proc_wr_addr = addr;
        bus.proc_wr_data = data;
        bus.proc_wr_strb = strb;
        #1;
        chk("wr_ready", bus.proc_wr_ready, 1);
        chk("rd_ready_no_req", bus.proc_rd_ready, 0);
        wr_q.push_back('{addr: addr, data: data, strb: strb});
        @(negedge clk);
        bus.proc_wr_en = 1'b0;
    endtask

    task automatic issue_rd(input logic [ADDR_W-1:0] addr);
        bus.proc_rd_en   = 1'b1;
        bus.proc_rd_addr = addr;
        #1;
        chk("rd_ready", bus.proc_rd_ready, 1);
        rq_q.push_back(addr);
        @(negedge clk);
        bus.proc_rd_en = 1'b0;
    endtask

    task automatic send_rs(input logic [DATA_W-1:0] data);
        bus.rdrs_pkt_valid = 1'b1;
        bus.rdrs_pkt_data  = data;
        rs_q.push_back(data);
        @(negedge clk);
        bus.rdrs_pkt_valid = 1'b0;
    endtask

    // Chain model for the tie-break test: read requests echo back three cycles later.
    logic [2:0]        lb_v;
    logic [DATA_W-1:0] lb_data;

    task automatic lb_step();
        bus.rdrs_pkt_valid = lb_v[2];
        bus.rdrs_pkt_data  = lb_data;
        if (lb_v[2]) begin
            rs_q.push_back(lb_data);
            lb_data = lb_data + 64'd1;
        end
        lb_v = {lb_v[1:0], bus.rdrq_pkt_en};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              turn_w;
        logic [ADDR_W-1:0] waddr, raddr;
        int                lat;

        idle_inputs();
        @(negedge clk);
        do_reset();

        // Single write after reset.
        issue_wr(22'h100, 64'hA5A5, 8'hFF);
        #1;
        chk("single_wr outst_cnt", bus.outst_cnt, 0);
        @(negedge clk);
        #1;
        chk("single_wr pkt one cycle", bus.wr_pkt_en, 0);
        @(negedge clk);

        // Continuous contention with a 3-deep response loopback.
        do_reset();
        lb_v    = 3'b000;
        lb_data = 64'h1000;
        turn_w  = 1'b1;
        waddr   = 22'h400;
        raddr   = 22'h500;
        for (int c = 0; c < 24; c++) begin
            lb_step();
            bus.proc_wr_en   = 1'b1;
            bus.proc_wr_addr = waddr;
            bus.proc_wr_data = 64'hBEEF_0000 + 64'(waddr);
            bus.proc_wr_strb = 8'h0F;
            bus.proc_rd_en   = 1'b1;
            bus.proc_rd_addr = raddr;
            #1;
            chk("tie wr_ready", bus.proc_wr_ready, turn_w);
            chk("tie rd_ready", bus.proc_rd_ready, !turn_w);
            chk("tie outst_cnt<=MAX", bus.outst_cnt <= 4'(MAX_OUTST), 1);
            if (turn_w) begin
                wr_q.push_back('{addr: waddr, data: 64'hBEEF_0000 + 64'(waddr), strb: 8'h0F});
                waddr = waddr + 22'd1;
            end else begin
                rq_q.push_back(raddr);
                raddr = raddr + 22'd1;
            end
            turn_w = !turn_w;
            @(negedge clk);
        end
        bus.proc_wr_en = 1'b0;
        bus.proc_rd_en = 1'b0;
        repeat (6) begin
            lb_step();
            @(negedge clk);
        end
        #1;
        chk("tie drained outst_cnt", bus.outst_cnt, 0);
        @(negedge clk);

        // Credit stall at MAX_OUTST.
        do_reset();
        bus.proc_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.proc_rd_addr = ADDR_W'(32'h200 + i);
            #1;
            chk("credit rd_ready", bus.proc_rd_ready, 1);
            rq_q.push_back(ADDR_W'(32'h200 + i));
            @(negedge clk);
        end
        bus.proc_rd_addr = 22'h204;
        #1;
        chk("credit stalled rd_ready", bus.proc_rd_ready, 0);
        chk("credit full outst_cnt", bus.outst_cnt, 4);
        bus.rdrs_pkt_valid = 1'b1;
        bus.rdrs_pkt_data  = 64'hCAFE;
        rs_q.push_back(64'hCAFE);
        @(negedge clk);
        bus.rdrs_pkt_valid = 1'b0;
        #1;
        chk("credit rd_data_valid", bus.proc_rd_data_valid, 1);
        chk("credit rd_ready back", bus.proc_rd_ready, 1);
        chk("credit outst_cnt after retire", bus.outst_cnt, 3);
        rq_q.push_back(22'h204);
        @(negedge clk);
        #1;
        chk("credit refilled rd_ready", bus.proc_rd_ready, 0);
        chk("credit refilled outst_cnt", bus.outst_cnt, 4);
        bus.proc_rd_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_rs(64'hD0 + 64'(i));
        #1;
        chk("credit drained outst_cnt", bus.outst_cnt, 0);
        @(negedge clk);

        // In-order return.
        issue_rd(22'h300);
        issue_rd(22'h304);
        issue_rd(22'h308);
        send_rs(64'h11);
        send_rs(64'h22);
        send_rs(64'h33);
        @(negedge clk);
        #1;
        chk("inorder outst_cnt", bus.outst_cnt, 0);
        chk("inorder rd_timeout_err", bus.rd_timeout_err, 0);
        @(negedge clk);

        // Timeout with no response.
        do_reset();
        issue_rd(22'h600);
        rs_q.push_back(64'h0);
        lat = 1;
        #1;
        while (bus.proc_rd_data_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("timeout latency", 64'(lat), 9);
        chk("timeout rd_timeout_err", bus.rd_timeout_err, 1);
        chk("timeout outst_cnt", bus.outst_cnt, 0);
        @(negedge clk);

        // Response on the expiry cycle wins.
        do_reset();
        issue_rd(22'h601);
        repeat (7) @(negedge clk);
        send_rs(64'h77);
        #1;
        chk("expiry rd_data_valid", bus.proc_rd_data_valid, 1);
        chk("expiry rd_timeout_err", bus.rd_timeout_err, 0);
        chk("expiry outst_cnt", bus.outst_cnt, 0);
        repeat (12) @(negedge clk);
        #1;
        chk("expiry no late timeout", bus.rd_timeout_err, 0);
        @(negedge clk);

        // Spurious response while idle.
        do_reset();
        bus.rdrs_pkt_valid = 1'b1;
        bus.rdrs_pkt_data  = 64'hBAD;
        @(negedge clk);
        bus.rdrs_pkt_valid = 1'b0;
        #1;
        chk("spurious err", bus.spurious_rs_err, 1);
        chk("spurious dropped", bus.proc_rd_data_valid, 0);
        @(negedge clk);

        // Reset with two reads outstanding; late responses become spurious.
        do_reset();
        issue_rd(22'h700);
        issue_rd(22'h701);
        #1;
        chk("midreset outst before", bus.outst_cnt, 2);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        bus.rdrs_pkt_valid = 1'b1;
        bus.rdrs_pkt_data  = 64'h700;
        @(negedge clk);
        bus.rdrs_pkt_data  = 64'h701;
        @(negedge clk);
        bus.rdrs_pkt_valid = 1'b0;
        #1;
        chk("midreset late spurious", bus.spurious_rs_err, 1);
        chk("midreset late outst", bus.outst_cnt, 0);
        repeat (3) @(negedge clk);

        chk("wr_q empty", 64'(wr_q.size()), 0);
        chk("rq_q empty", 64'(rq_q.size()), 0);
        chk("rs_q empty", 64'(rs_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/glb_proc_req_sched.md
# glb_proc_req_sched

Processor-side request scheduler for the global buffer processor packet chain. Sits between the processor interface and the first tile's `packet_w2e_wsti` injection point. Arbitrates the processor's write and read-request streams into one issue slot per cycle, caps outstanding reads with a credit counter, and returns read responses from the chain in order. Retires reads that time out and flags them.

## Interface
- `ADDR_W`, 22: processor byte-address width
- `DATA_W`, 64: data width, equal to the bank data width
- `MAX_OUTST`, 4: maximum number of outstanding reads, 1..15
- `RD_TIMEOUT`, 64: cycles without a response before the oldest read is retired, 2..255
- `clk`  in  1  clock
- `reset`  in  1  reset; asynchronous, active-low (asserted at 0)
- `proc_wr_en`  in  1  write request valid
- `proc_wr_strb`  in  DATA_W/8  byte strobes
- `proc_wr_addr`  in  ADDR_W  write address
- `proc_wr_data`  in  DATA_W  write data
- `proc_wr_ready`  out  1  write accepted this cycle when high with `proc_wr_en`
- `proc_rd_en`  in  1  read request valid
- `proc_rd_addr`  in  ADDR_W  read address
- `proc_rd_ready`  out  1  read accepted this cycle when high with `proc_rd_en`
- `proc_rd_data`  out  DATA_W  read data
- `proc_rd_data_valid`  out  1  one-cycle pulse for each retired read
- `wr_pkt_en`, `wr_pkt_strb`, `wr_pkt_addr`, `wr_pkt_data`  out  1/DATA_W/8/ADDR_W/DATA_W  write packet into the chain
- `rdrq_pkt_en`, `rdrq_pkt_addr`  out  1/ADDR_W  read-request packet into the chain
- `rdrs_pkt_valid`, `rdrs_pkt_data`  in  1/DATA_W  read response from the chain
- `outst_cnt`  out  4  current outstanding-read count
- `rd_timeout_err`  out  1  sticky; cleared only by reset
- `spurious_rs_err`  out  1  sticky; cleared only by reset

## Operation
- **Eligibility.** A write is eligible when `proc_wr_en` is high. A read is eligible when `proc_rd_en` is high and `outst_cnt < MAX_OUTST`.
- **Issue.** At most one request is granted per cycle.
  - If only one request is eligible, it wins.
  - If both are eligible, round-robin decides using the `last_grant` register. The request type not granted last time wins. `last_grant` resets to "read", so a write wins the first tie.
- **Ready signals.** `proc_wr_ready` and `proc_rd_ready` are the grant signals and are combinational from the enables and state. Each requester must hold its request (en and payload) stable until its ready is seen high.
- **Packet output.** A granted request is registered onto the packet outputs for exactly one cycle. Fields of the packet type not issued are driven to 0.
- **Outstanding count.**
  - Increments on a read grant.
  - Decrements on a retire (response or timeout).
  - When a grant and a retire happen in the same cycle, the count is unchanged.
- **Response.** Responses return in issue order, so no tag is carried. `rdrs_pkt_valid` with `outst_cnt > 0` retires the oldest read: `proc_rd_data <= rdrs_pkt_data` and `proc_rd_data_valid` pulses.
- **Spurious response.** `rdrs_pkt_valid` with `outst_cnt == 0` is dropped and sets `spurious_rs_err`.
- **Timeout.**
  - `to_cnt` (8 bit) clears to 0 when `outst_cnt == 0` or when a response arrives. Otherwise it increments.
  - When `to_cnt == RD_TIMEOUT-1` and no response arrives that cycle, the oldest read retires: `proc_rd_data <= 0`, `proc_rd_data_valid` pulses, `rd_timeout_err` sets, and `to_cnt` clears.
  - A response arriving on the expiry cycle wins and no error is raised.
- **Reset mid-operation.** Outstanding reads are discarded and not answered. Responses arriving after reset are spurious.

## Timing
- **Reset values.** All outputs are 0. `outst_cnt`, `to_cnt` and the sticky errors are 0. `last_grant` is "read".
- **Ready.** Ready is a same-cycle combinational response to en.
- **Request latency.** A request accepted at edge N appears on `*_pkt_*` during cycle N+1, for 1 cycle.
- **Response latency.** `rdrs_pkt_valid` in cycle N produces `proc_rd_data_valid` in cycle N+1.
- **Throughput.** One request per cycle. Alternating tie-break gives 50/50 under continuous contention.
- **Credit limit.** With `outst_cnt == MAX_OUTST`, `proc_rd_ready` is 0. It rises in the cycle after the retiring response is registered, because `outst_cnt` is a register.

## Test plan
- **Reset and single write.** Reset, then a single write (addr 0x100, data 0xA5A5, strb 0xFF). Required: `proc_wr_ready` is 1 in the same cycle; `wr_pkt_en` is 1 for exactly one cycle with matching fields; all other outputs stay 0.
- **Tie-break.** Hold `proc_wr_en` and `proc_rd_en` high continuously with the response loopback 3 cycles deep. Required: grants go W, R, W, R…; packets alternate; `outst_cnt` never exceeds 4.
- **Credit stall.** Issue 4 reads with no response. Required: `proc_rd_ready` = 0 with `outst_cnt` = 4. Then send one response. Required: `proc_rd_data_valid` appears one cycle later, and `proc_rd_ready` returns on the following cycle.
- **In-order return.** Issue reads A, B, C, then send responses 0x11, 0x22, 0x33. Required: `proc_rd_data` returns 0x11, 0x22, 0x33 in order, with `outst_cnt` = 0 at the end.
- **Timeout.** With `RD_TIMEOUT` = 8, issue one read and send no response. Required: a `proc_rd_data_valid` pulse with data 0 and `rd_timeout_err` = 1 about 8 cycles after issue. A response on the expiry cycle instead returns its data with no error.
- **Spurious response and mid-operation reset.** Send `rdrs_pkt_valid` while idle. Required: it is dropped and `spurious_rs_err` = 1. Assert reset with 2 reads outstanding. Required: all outputs are 0 immediately (asynchronous reset) and the late responses are flagged spurious.
